// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for four requesters. The grant is presented as a registered
// decoder enable/address pair (E, A) plus a one-hot gnt, and tenure is bounded by MAX_HOLD.
module decoder_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] req,
  input  logic       done,
  output logic       E,
  output logic [1:0] A,
  output logic [3:0] gnt,
  output logic       busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] a_q, a_d;
  logic [1:0] last_q, last_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] gnt_q, gnt_d;

  logic [3:0] others;
  logic [3:0] scan_src;
  logic [1:0] scan_idx;
  logic [1:0] sel;
  logic       sel_vld;
  logic       timeout;
  logic       release_ev;

  assign others     = req & ~(4'b0001 << a_q);
  assign timeout    = (hold_q == HOLD_LAST) && (others != 4'b0000);
  assign release_ev = done || !req[a_q] || timeout;

  // Rotating-priority scan starting one past the last grantee. While granted, the
  // current owner is masked out, so the scan only finds a different requester.
  always_comb begin
    scan_src = (state_q == GRANT) ? others : req;
    scan_idx = last_q;
    sel      = last_q;
    sel_vld  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = last_q + 2'(k);
      if (!sel_vld && scan_src[scan_idx]) begin
        sel     = scan_idx;
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d = GRANT;
          a_d     = sel;
          last_d  = sel;
          hold_d  = 4'd0;
        end
      end
      GRANT: begin
        if (release_ev) begin
          hold_d = 4'd0;
          if (sel_vld) begin
            a_d    = sel;
            last_d = sel;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d = (state_d == GRANT) ? (4'b0001 << a_d) : 4'b0000;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      a_q     <= 2'b00;
      last_q  <= 2'b11;
      hold_q  <= 4'd0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  assign E    = (state_q == GRANT);
  assign busy = (state_q == GRANT);
  assign A    = a_q;
  assign gnt  = gnt_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter: a cycle-level ownership model is checked
// on every falling edge, and hand-computed grant sequences are checked after each step.
module tb_decoder_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       nrst;
  logic [3:0] req;
  logic       done;
  logic       E;
  logic [1:0] A;
  logic [3:0] gnt;
  logic       busy;

  int vec_cnt = 0;
  int err_cnt = 0;
  bit chk_en  = 1'b0;

  decoder_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk  (clk),
    .nrst (nrst),
    .req  (req),
    .done (done),
    .E    (E),
    .A    (A),
    .gnt  (gnt),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Ownership model: who owns the resource, how many cycles it has owned it,
  // and who was served most recently.
  bit         m_busy = 1'b0;
  logic [1:0] m_a    = 2'd0;
  logic [1:0] m_last = 2'd3;
  int         m_held = 0;
  logic [3:0] waiting;

  function automatic logic [1:0] pick(input logic [1:0] last, input logic [3:0] mask);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (int'(last) + k) % 4;
      if (mask[idx]) return 2'(idx);
    end
    return last;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_busy = 1'b0;
      m_a    = 2'd0;
      m_last = 2'd3;
      m_held = 0;
    end else if (!m_busy) begin
      if (req != 4'b0000) begin
        m_a    = pick(m_last, req);
        m_last = m_a;
        m_busy = 1'b1;
        m_held = 1;
      end
    end else begin
      waiting       = req;
      waiting[m_a]  = 1'b0;
      if (done || !req[m_a] || (m_held >= MAX_HOLD && waiting != 4'b0000)) begin
        if (waiting != 4'b0000) begin
          m_a    = pick(m_last, waiting);
          m_last = m_a;
          m_held = 1;
        end else begin
          m_busy = 1'b0;
        end
      end else begin
        m_held = m_held + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_gnt", gnt, m_busy ? (4'b0001 << m_a) : 4'b0000);
      chk("mdl_E", {3'b000, E}, {3'b000, m_busy});
      chk("mdl_busy", {3'b000, busy}, {3'b000, m_busy});
      chk("mdl_A", {2'b00, A}, {2'b00, m_a});
    end
  end

  task automatic cyc(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    req  = 4'b0000;
    done = 1'b0;
    nrst = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  logic [3:0] exp_q[$];

  initial begin
    req  = 4'b0000;
    done = 1'b0;
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_E", {3'b000, E}, 4'b0000);
    chk("rst_A", {2'b00, A}, 4'b0000);
    chk("rst_busy", {3'b000, busy}, 4'b0000);
    nrst = 1'b1;

    // First edge after reset release with no request: still at reset values.
    cyc(4'b0000, 1'b0);
    chk("post_rst_gnt", gnt, 4'b0000);
    // done while idle is ignored.
    cyc(4'b0000, 1'b1);
    chk("idle_done_gnt", gnt, 4'b0000);

    // Single request on requester 2, then withdrawal.
    cyc(4'b0100, 1'b0);
    chk("r2_gnt", gnt, 4'b0100);
    chk("r2_A", {2'b00, A}, 4'b0010);
    chk("r2_busy", {3'b000, busy}, 4'b0001);
    cyc(4'b0000, 1'b0);
    chk("r2_off_gnt", gnt, 4'b0000);
    chk("r2_off_busy", {3'b000, busy}, 4'b0000);
    chk("r2_off_A_hold", {2'b00, A}, 4'b0010);

    // All four requesting, done pulsed every grant: full rotation from 0.
    reset_dut();
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    cyc(4'b1111, 1'b0);
    chk("rot_0", gnt, exp_q.pop_front());
    for (int i = 1; i <= 4; i++) begin
      cyc(4'b1111, 1'b1);
      chk($sformatf("rot_%0d", i), gnt, exp_q.pop_front());
    end

    // Two requesters, no done: each held exactly MAX_HOLD cycles, then wrap.
    reset_dut();
    exp_q = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
              4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    for (int i = 0; i < 9; i++) begin
      cyc(4'b0011, 1'b0);
      chk($sformatf("hold_%0d", i), gnt, exp_q.pop_front());
    end

    // Lone requester keeps the grant indefinitely; a late rival preempts at once.
    reset_dut();
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0001, 1'b0);
      chk($sformatf("sat_%0d", i), gnt, 4'b0001);
    end
    cyc(4'b0011, 1'b0);
    chk("sat_preempt", gnt, 4'b0010);

    // done and req drop together: single release, straight to requester 3.
    reset_dut();
    cyc(4'b1010, 1'b0);
    chk("dr_first", gnt, 4'b0010);
    cyc(4'b1000, 1'b1);
    chk("dr_next", gnt, 4'b1000);
    chk("dr_busy", {3'b000, busy}, 4'b0001);

    // Asynchronous reset in the middle of a grant.
    reset_dut();
    cyc(4'b1100, 1'b0);
    chk("ar_before", gnt, 4'b0100);
    nrst = 1'b0;
    #1;
    chk("ar_gnt_now", gnt, 4'b0000);
    chk("ar_E_now", {3'b000, E}, 4'b0000);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    cyc(4'b1100, 1'b0);
    chk("ar_regrant", gnt, 4'b0100);

    // Model-only stretch with a varied request pattern and done pulses.
    for (int i = 0; i < 40; i++) begin
      cyc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
